// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, timeout default, memory-stage FSM states and the MEM/WB record.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int TIMEOUT_DEFAULT = 15;
  typedef enum logic {IDLE, WAIT} mem_state_e;
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [REG_W-1:0]  mux;
  } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load enable and bubble insertion.
//   clk, reset (sync, active-low) | en_i loads d_i | bubble_i clears the control bits | q_o register contents
module mem_wb_reg
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en_i,
  input  logic    bubble_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);
  mem_wb_t wb_q;
  // A bubble overrides only the control bits; data fields follow en_i.
  always_ff @(posedge clk)
    if (!reset) wb_q <= '0;
    else begin
      if (en_i) wb_q <= d_i;
      if (bubble_i) begin
        wb_q.reg_write <= 1'b0;
        wb_q.mem_to_reg <= 1'b0;
      end
    end
  assign q_o = wb_q;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with branch resolution, stalling data-bus access FSM, timeout and MEM/WB register.
//   clk, reset (sync, active-low) | EX/MEM controls and data in | PCSrc/BranchTarget to fetch, stall to EX/MEM
//   mem_req/we/addr/wdata, mem_rdata/ack data bus | *_Out MEM/WB outputs | bus_error sticky fault flag
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Branch,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] Add,
  input  logic              Zero,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  Mux,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic [DATA_W-1:0] ReadData_Out,
  output logic [DATA_W-1:0] ALUResult_Out,
  output logic [REG_W-1:0]  Mux_Out,
  output logic              bus_error
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, bus_error_q, bus_error_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic access, aligned, start, misaligned, in_wait, timeout;
  mem_wb_t wb_d, wb_q;
  assign PCSrc = Branch & Zero;
  assign BranchTarget = Add;
  assign access = MemRead | MemWrite;
  assign aligned = ALUResult[1:0] == 2'b00;
  assign in_wait = state_q == WAIT;
  assign start = state_q == IDLE && access && aligned;
  assign misaligned = state_q == IDLE && access && !aligned;
  // mem_ack wins over an expiring counter in the same cycle.
  assign timeout = in_wait && !mem_ack && cnt_q == CNT_W'(TIMEOUT_CYCLES);
  assign stall = reset && (start || (in_wait && !mem_ack && !timeout));
  always_comb begin
    state_d = state_q;
    if (start) state_d = WAIT;
    else if (in_wait && (mem_ack || timeout)) state_d = IDLE;
    cnt_d = (in_wait && !mem_ack && !timeout) ? cnt_q + CNT_W'(1) : '0;
    mem_req_d = state_d == WAIT;
    mem_we_d = start ? MemWrite : mem_we_q;
    mem_addr_d = start ? ALUResult : mem_addr_q;
    mem_wdata_d = start ? ReadData2 : mem_wdata_q;
    bus_error_d = bus_error_q | misaligned | timeout;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_error_q <= bus_error_d;
    end
  // An abandoned load must not write back; an abandoned ALU-style write-back still may.
  assign wb_d = '{
    reg_write:  timeout ? (RegWrite && !MemtoReg) : RegWrite,
    mem_to_reg: MemtoReg,
    read_data:  (in_wait && mem_ack && !mem_we_q) ? mem_rdata : '0,
    alu_result: ALUResult,
    mux:        Mux
  };
  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .reset    (reset),
    .en_i     (!stall),
    .bubble_i (stall || misaligned),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_error = bus_error_q;
  assign RegWrite_Out = wb_q.reg_write;
  assign MemtoReg_Out = wb_q.mem_to_reg;
  assign ReadData_Out = wb_q.read_data;
  assign ALUResult_Out = wb_q.alu_result;
  assign Mux_Out = wb_q.mux;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage covering loads, stores, waits, timeout, misalignment, branch and reset.
module tb_mem_stage;
  localparam int TO = 15;
  logic clk = 1'b0, reset = 1'b0;
  logic Branch = 0, MemRead = 0, MemtoReg = 0, MemWrite = 0, RegWrite = 0, Zero = 0;
  logic [31:0] Add = 0, ALUResult = 0, ReadData2 = 0, mem_rdata = 0;
  logic [4:0] Mux = 0;
  logic mem_ack = 0;
  logic PCSrc, stall, mem_req, mem_we, RegWrite_Out, MemtoReg_Out, bus_error;
  logic [31:0] BranchTarget, mem_addr, mem_wdata, ReadData_Out, ALUResult_Out;
  logic [4:0] Mux_Out;
  int checks = 0, errors = 0;
  typedef struct {
    logic rw;
    logic m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0] mux;
    bit bub;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .Add(Add), .Zero(Zero), .ALUResult(ALUResult),
    .ReadData2(ReadData2), .Mux(Mux), .PCSrc(PCSrc), .BranchTarget(BranchTarget), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .RegWrite_Out(RegWrite_Out),
    .MemtoReg_Out(MemtoReg_Out), .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out),
    .Mux_Out(Mux_Out), .bus_error(bus_error)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_berr"}, bus_error, 0);
    check({tag, "_rw"}, RegWrite_Out, 0);
    check({tag, "_m2r"}, MemtoReg_Out, 0);
    check({tag, "_rd"}, ReadData_Out, 0);
    check({tag, "_alu"}, ALUResult_Out, 0);
    check({tag, "_mux"}, Mux_Out, 0);
  endtask
  // n >= 0: ack on WAIT cycle index n; n < 0: never ack. Called right after a posedge.
  task automatic run_op(input string tag, input logic br, input logic z, input logic mr,
                        input logic m2r, input logic mw, input logic rw, input logic [31:0] add,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] mux,
                        input int n, input logic [31:0] rdata, input bit ack_idle);
    exp_t e, got;
    bit acc, al;
    int stalls, exp_stalls;
    acc = mr | mw;
    al = alu[1:0] == 2'b00;
    Branch = br; Zero = z; MemRead = mr; MemtoReg = m2r; MemWrite = mw; RegWrite = rw;
    Add = add; ALUResult = alu; ReadData2 = wd; Mux = mux; mem_rdata = rdata;
    e.bub = acc && !al;
    e.rw = e.bub ? 1'b0 : (acc && n < 0) ? (rw && !m2r) : rw;
    e.m2r = e.bub ? 1'b0 : m2r;
    e.rdata = (acc && !mw && n >= 0) ? rdata : 32'h0;
    e.alu = alu;
    e.mux = mux;
    sb.push_back(e);
    exp_stalls = (acc && al) ? ((n >= 0) ? n + 1 : TO + 1) : 0;
    stalls = 0;
    for (int c = 0; c < 64; c++) begin
      mem_ack = acc && al && ((c == 0 && ack_idle) || (c >= 1 && n >= 0 && c - 1 == n));
      @(negedge clk);
      if (c == 0) begin
        check({tag, "_pcsrc"}, PCSrc, br & z);
        check({tag, "_btgt"}, BranchTarget, add);
        check({tag, "_req_idle"}, mem_req, 0);
      end else begin
        check({tag, "_req_wait"}, mem_req, 1);
        check({tag, "_we"}, mem_we, mw);
        check({tag, "_addr"}, mem_addr, alu);
        check({tag, "_wdata"}, mem_wdata, wd);
        check({tag, "_bubble"}, RegWrite_Out, 0);
      end
      if (!stall) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    check({tag, "_stalls"}, stalls, exp_stalls);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    got = sb.pop_front();
    check({tag, "_rw_out"}, RegWrite_Out, got.rw);
    check({tag, "_m2r_out"}, MemtoReg_Out, got.m2r);
    if (!got.bub) begin
      check({tag, "_rd_out"}, ReadData_Out, got.rdata);
      check({tag, "_alu_out"}, ALUResult_Out, got.alu);
      check({tag, "_mux_out"}, Mux_Out, got.mux);
    end
    check({tag, "_req_done"}, mem_req, 0);
  endtask
  initial begin
    MemRead = 1'b1;
    @(negedge clk);
    check("rst_stall", stall, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero_outputs("rst");
    reset = 1'b1;
    MemRead = 1'b0;
    run_op("branch", 1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0);
    run_op("nobranch", 1, 0, 0, 0, 0, 1, 32'h404, 32'h8, 32'h0, 5'd4, 0, 32'h0, 0);
    run_op("load0", 0, 0, 1, 1, 0, 1, 32'h0, 32'h100, 32'h0, 5'd9, 0, 32'hDEADBEEF, 0);
    run_op("store3", 0, 0, 0, 0, 1, 0, 32'h0, 32'h40, 32'h12345678, 5'd3, 3, 32'hFFFF0000, 0);
    run_op("alu", 0, 0, 0, 0, 0, 1, 32'h0, 32'hCAFE0001, 32'h0, 5'd17, 0, 32'h0, 0);
    run_op("ackidle", 0, 0, 1, 1, 0, 1, 32'h0, 32'h88, 32'h0, 5'd21, 2, 32'h0BADF00D, 1);
    run_op("ackedge", 0, 0, 1, 1, 0, 1, 32'h0, 32'h9C, 32'h0, 5'd5, TO, 32'hA5A5A5A5, 0);
    check("ackedge_berr", bus_error, 0);
    run_op("misalign", 0, 0, 1, 1, 0, 1, 32'h0, 32'h102, 32'h0, 5'd6, 0, 32'h11111111, 0);
    check("misalign_berr", bus_error, 1);
    run_op("load_after", 0, 0, 1, 1, 0, 1, 32'h0, 32'h104, 32'h0, 5'd8, 1, 32'h22222222, 0);
    check("sticky_berr", bus_error, 1);
    run_op("timeout", 0, 0, 1, 1, 0, 1, 32'h0, 32'h200, 32'h0, 5'd10, -1, 32'h33333333, 0);
    check("timeout_berr", bus_error, 1);
    run_op("timeout_alu", 0, 0, 1, 0, 0, 1, 32'h0, 32'h204, 32'h0, 5'd11, -1, 32'h44444444, 0);
    MemRead = 1; MemtoReg = 1; RegWrite = 1; MemWrite = 0; Branch = 0;
    ALUResult = 32'h300; Mux = 5'd12; mem_rdata = 32'h55555555; mem_ack = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rstwait_req_before", mem_req, 1);
    reset = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    check("rstwait_stall", stall, 0);
    @(posedge clk);
    #1;
    check_zero_outputs("rstwait");
    reset = 1'b1;
    mem_ack = 1'b0;
    MemRead = 0; MemtoReg = 0; RegWrite = 0; ALUResult = 0; Mux = 0;
    run_op("post_rst", 0, 0, 1, 1, 0, 1, 32'h0, 32'h10, 32'h0, 5'd13, 1, 32'h66666666, 0);
    check("post_rst_berr", bus_error, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
